rom_burst_reader: RTL and testbench

Parametrised synchronous ROM with a request/response streaming interface, successor to the fixed 8 x 16 chip-select ROM. Accepts single or burst read requests (auto-incrementing address, optional wrap), reads the array with one cycle of latency, and delivers words through a 2-entry output buffer with valid/ready backpressure. Sits between a memory-mapped master (sequencer, DMA, table walker) and constant/coefficient storage.

---
 rtl/rom_burst_reader.sv | 144 ++++++++++++++
 tb/tb_rom_burst_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_burst_reader.sv
// rom_burst_reader: parametrised synchronous ROM serving single/burst reads through a 2-entry valid/ready output buffer.
// Build macro ROM_PARITY_EN adds rd_par_o, the even parity of each word, carried alongside the data.
module rom_burst_reader #(
    parameter int                                DATA_W    = 16,
    parameter int                                ADDR_W    = 3,
    parameter int                                LEN_W     = 4,
    parameter string                             INIT_FILE = "rom_init.mem",
    parameter logic [(2**ADDR_W)*DATA_W-1:0]     INIT_DATA = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cs_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [LEN_W-1:0]  req_len_i,
    input  logic              req_wrap_i,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_last_o,
    output logic              busy_o
`ifdef ROM_PARITY_EN
   ,output logic              rd_par_o
`endif
);
    localparam int DEPTH = 2**ADDR_W;

    // state   | meaning
    // S_IDLE  | waiting for a request (earlier beats may still be draining)
    // S_BURST | issuing one array read per cycle while buffer space allows
    typedef enum logic {S_IDLE, S_BURST} state_t;

    logic [DATA_W-1:0] rom_mem [DEPTH];

    // ROM image taken from INIT_DATA.
    initial begin
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = INIT_DATA[i*DATA_W +: DATA_W];
    end

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  rem_q;
    logic              wrap_q;
    logic              infl_q;
    logic [DATA_W-1:0] infl_data_q;
    logic              infl_last_q;
    logic [DATA_W-1:0] fifo_data_q [2];
    logic [1:0]        fifo_last_q;
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;
`ifdef ROM_PARITY_EN
    logic              infl_par_q;
    logic [1:0]        fifo_par_q;
`endif

    logic       req_fire;
    logic       pop;
    logic       push;
    logic       issue;
    logic       last_issue;
    logic [2:0] occ;

    assign req_ready_o = cs_i && (state_q == S_IDLE) && !rst_i;
    assign req_fire    = req_valid_i && req_ready_o;
    assign rd_valid_o  = (count_q != 2'd0);
    assign rd_data_o   = fifo_data_q[rd_ptr_q];
    assign rd_last_o   = fifo_last_q[rd_ptr_q];
    assign busy_o      = (state_q == S_BURST) || infl_q || (count_q != 2'd0);
`ifdef ROM_PARITY_EN
    assign rd_par_o    = fifo_par_q[rd_ptr_q];
`endif

    // Buffer occupancy counts the read in flight, so the FIFO can never overflow.
    assign pop        = rd_valid_o && rd_ready_i;
    assign push       = infl_q;
    assign occ        = {1'b0, count_q} + {2'b00, infl_q};
    assign issue      = (state_q == S_BURST) && (occ < (3'd2 + {2'b00, pop}));
    assign last_issue = (rem_q == '0) || ((&addr_q) && !wrap_q);
    assign count_d    = count_q + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            rem_q          <= '0;
            wrap_q         <= 1'b0;
            infl_q         <= 1'b0;
            infl_data_q    <= '0;
            infl_last_q    <= 1'b0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q    <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            count_q        <= '0;
`ifdef ROM_PARITY_EN
            infl_par_q     <= 1'b0;
            fifo_par_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_fire) begin
                        addr_q  <= req_addr_i;
                        rem_q   <= req_len_i;
                        wrap_q  <= req_wrap_i;
                        state_q <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (issue) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        rem_q  <= rem_q - LEN_W'(1);
                        if (last_issue) state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            infl_q <= issue;
            if (issue) begin
                infl_data_q <= rom_mem[addr_q];
                infl_last_q <= last_issue;
`ifdef ROM_PARITY_EN
                infl_par_q  <= ^rom_mem[addr_q];
`endif
            end

            if (push) begin
                fifo_data_q[wr_ptr_q] <= infl_data_q;
                fifo_last_q[wr_ptr_q] <= infl_last_q;
`ifdef ROM_PARITY_EN
                fifo_par_q[wr_ptr_q]  <= infl_par_q;
`endif
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed, table-driven bench for rom_burst_reader; ROM image word i = 16'hA000 + i, DEPTH 8.
// Build with ROM_PARITY_EN defined to also check rd_par on every beat.
module tb_rom_burst_reader;
    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_addr;
    logic [3:0]  req_len;
    logic        req_wrap;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        rd_last;
    logic        busy;
`ifdef ROM_PARITY_EN
    logic        rd_par;
`endif

    always #5 clk = ~clk;

    rom_burst_reader #(
        .DATA_W    (16),
        .ADDR_W    (3),
        .LEN_W     (4),
        .INIT_FILE (""),
        .INIT_DATA ({16'hA007, 16'hA006, 16'hA005, 16'hA004,
                     16'hA003, 16'hA002, 16'hA001, 16'hA000})
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cs_i        (cs),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_len_i   (req_len),
        .req_wrap_i  (req_wrap),
        .rd_valid_o  (rd_valid),
        .rd_ready_i  (rd_ready),
        .rd_data_o   (rd_data),
        .rd_last_o   (rd_last),
        .busy_o      (busy)
`ifdef ROM_PARITY_EN
       ,.rd_par_o    (rd_par)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Beat log, written only by the monitor below.
    logic [15:0] bq_data [$];
    logic        bq_last [$];
    int          bq_cyc  [$];
    int          stab_bad = 0;
    int          par_bad = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_d = '0;
    logic        prev_l = 1'b0;

    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            bq_data.push_back(rd_data);
            bq_last.push_back(rd_last);
            bq_cyc.push_back(cyc);
`ifdef ROM_PARITY_EN
            if (rd_par !== ^rd_data) par_bad = par_bad + 1;
`endif
        end
        if (prev_stall && !rst && (rd_valid !== 1'b1 || rd_data !== prev_d || rd_last !== prev_l))
            stab_bad = stab_bad + 1;
        prev_stall = !rst && rd_valid && !rd_ready;
        prev_d     = rd_data;
        prev_l     = rd_last;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic [3:0]  len;
        logic        wrap;
        int          rdy_mode;   // 0: ready held high, 1: toggle then hold low 5 cycles
        int          n;
        logic [15:0] last_word;
    } vec_t;

    vec_t tbl [8];

    task automatic run_vec(input vec_t v);
        int base;
        int acc;
        int c;
        logic [15:0] e;
        @(posedge clk); #1;
        req_addr  = v.addr;
        req_len   = v.len;
        req_wrap  = v.wrap;
        req_valid = 1'b1;
        rd_ready  = 1'b1;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        base = bq_data.size();
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 1'b0;
        c = 0;
        while ((bq_data.size() - base) < v.n && c < 200) begin
            if (v.rdy_mode == 1)
                rd_ready = (c < 6) ? ((c % 2) == 1) : (c >= 11);
            @(posedge clk); #1;
            c++;
        end
        rd_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("beat_count", bq_data.size() - base, v.n);
        chk("busy_after_burst", busy, 0);
        for (int k = 0; k < v.n && (base + k) < bq_data.size(); k++) begin
            e = 16'hA000 | 16'((int'(v.addr) + k) & 7);
            chk("beat_data", bq_data[base + k], e);
            chk("beat_last", bq_last[base + k], (k == v.n - 1));
            if (v.rdy_mode == 0) chk("beat_timing", bq_cyc[base + k], acc + 2 + k);
        end
        if ((bq_data.size() - base) == v.n)
            chk("final_word", bq_data[base + v.n - 1], v.last_word);
    endtask

    initial begin
        int base;
        int acc;
        int c;

        tbl[0] = '{addr: 3'd3, len: 4'd0,  wrap: 1'b0, rdy_mode: 0, n: 1,  last_word: 16'hA003};
        tbl[1] = '{addr: 3'd2, len: 4'd3,  wrap: 1'b0, rdy_mode: 0, n: 4,  last_word: 16'hA005};
        tbl[2] = '{addr: 3'd6, len: 4'd3,  wrap: 1'b1, rdy_mode: 0, n: 4,  last_word: 16'hA001};
        tbl[3] = '{addr: 3'd6, len: 4'd3,  wrap: 1'b0, rdy_mode: 0, n: 2,  last_word: 16'hA007};
        tbl[4] = '{addr: 3'd0, len: 4'd7,  wrap: 1'b0, rdy_mode: 1, n: 8,  last_word: 16'hA007};
        tbl[5] = '{addr: 3'd5, len: 4'd15, wrap: 1'b1, rdy_mode: 0, n: 16, last_word: 16'hA004};
        tbl[6] = '{addr: 3'd7, len: 4'd0,  wrap: 1'b0, rdy_mode: 0, n: 1,  last_word: 16'hA007};
        tbl[7] = '{addr: 3'd7, len: 4'd5,  wrap: 1'b0, rdy_mode: 0, n: 1,  last_word: 16'hA007};

        rst = 1'b1; cs = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0;
        req_wrap = 1'b0; rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_busy", busy, 0);
`ifdef ROM_PARITY_EN
        chk("rst_rd_par", rd_par, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", req_ready, 1);

        // cs low blocks acceptance
        @(posedge clk); #1;
        cs = 1'b0; req_valid = 1'b1; req_addr = 3'd1; req_len = 4'd2;
        base = bq_data.size();
        @(negedge clk);
        chk("cs0_req_ready", req_ready, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("cs0_no_beats", bq_data.size() - base, 0);
        chk("cs0_busy", busy, 0);
        req_valid = 1'b0; cs = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // cs dropped mid-burst: burst completes, pending request stays unaccepted
        @(posedge clk); #1;
        req_addr = 3'd1; req_len = 4'd4; req_wrap = 1'b0; req_valid = 1'b1;
        base = bq_data.size();
        @(posedge clk); #1;
        cs = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("csdrop_beats", bq_data.size() - base, 5);
        chk("csdrop_busy", busy, 0);
        chk("csdrop_req_ready", req_ready, 0);
        if (bq_data.size() >= base + 5) begin
            chk("csdrop_final_data", bq_data[base + 4], 16'hA005);
            chk("csdrop_final_last", bq_last[base + 4], 1);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; cs = 1'b1;

        // Back-to-back bursts: second accepted while first drains, order kept
        @(posedge clk); #1;
        req_addr = 3'd0; req_len = 4'd1; req_wrap = 1'b0; req_valid = 1'b1;
        base = bq_data.size();
        @(posedge clk); #1;
        acc = cyc;
        req_addr = 3'd4; req_len = 4'd1;
        c = 0;
        @(negedge clk);
        while (!req_ready && c < 20) begin
            @(negedge clk);
            c++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("b2b_beats", bq_data.size() - base, 4);
        if (bq_data.size() >= base + 4) begin
            chk("b2b_d0", bq_data[base],     16'hA000);
            chk("b2b_d1", bq_data[base + 1], 16'hA001);
            chk("b2b_d2", bq_data[base + 2], 16'hA004);
            chk("b2b_d3", bq_data[base + 3], 16'hA005);
            chk("b2b_last1", bq_last[base + 1], 1);
            chk("b2b_last2", bq_last[base + 2], 0);
            chk("b2b_t0", bq_cyc[base],     acc + 2);
            chk("b2b_t1", bq_cyc[base + 1], acc + 3);
            chk("b2b_t2", bq_cyc[base + 2], acc + 5);
            chk("b2b_t3", bq_cyc[base + 3], acc + 6);
        end

        // Reset two beats into a len-7 burst
        @(posedge clk); #1;
        req_addr = 3'd0; req_len = 4'd7; req_wrap = 1'b0; req_valid = 1'b1; rd_ready = 1'b1;
        base = bq_data.size();
        @(posedge clk); #1;
        req_valid = 1'b0;
        c = 0;
        while ((bq_data.size() - base) < 2 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_rd_valid", rd_valid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_req_ready", req_ready, cs);
        chk("rstmid_rd_data", rd_data, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rstmid_beats", bq_data.size() - base, 2);
        run_vec(tbl[0]);

        chk("hold_while_stalled", stab_bad, 0);
`ifdef ROM_PARITY_EN
        chk("parity", par_bad, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
